// File: rtl/output_compare_gen_pkg.sv
// rtl/output_compare_gen_pkg.sv - shared mode codes, timer selects and defaults for output compare
package output_compare_gen_pkg;

    typedef enum logic [1:0] {
        OC_OFF    = 2'b00,
        OC_TOGGLE = 2'b01,
        OC_PULSE  = 2'b10,
        OC_CYCLIC = 2'b11
    } oc_mode_e;

    localparam logic [1:0] OC_TMR0 = 2'b00;
    localparam logic [1:0] OC_TMR1 = 2'b01;

    localparam int OC_DEF_FIFO_DEPTH = 4;
    localparam int OC_DEF_TW         = 16;

endpackage

// File: rtl/output_compare_gen_fifo.sv
// rtl/output_compare_gen_fifo.sv - compare-value FIFO with two ordered push ports and one pop
module output_compare_gen_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0_i,
    input  logic [W-1:0]             push0_data_i,
    input  logic                     push1_i,
    input  logic [W-1:0]             push1_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] wr_ptr1;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          pop_ok;

    // push1 lands behind push0 when both fire, giving recirculation priority
    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        wr_ptr1  = wr_ptr_q + AW'(push0_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push0_i) + AW'(push1_i);
        count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
        if (push1_i) mem_q[wr_ptr1]  <= push1_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/output_compare_gen.sv
// rtl/output_compare_gen.sv - timer-match waveform generator driven by a queue of compare values
module output_compare_gen
    import output_compare_gen_pkg::*;
#(
    parameter int FIFO_DEPTH = OC_DEF_FIFO_DEPTH,
    parameter int TW         = OC_DEF_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    OCTMR,
    input  logic [1:0]    OCM,
    input  logic [TW-1:0] t_val_bi_0,
    input  logic [TW-1:0] t_val_bi_1,
    input  logic          wr_i,
    input  logic [TW-1:0] OCBUF_i,
    input  logic          clr_i,
    output logic          oc_out,
    output logic          OCMF,
    output logic          OCBNF,
    output logic          OCBE,
    output logic          OCOV
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    oc_mode_e      mode;
    logic [TW-1:0] t_cur;
    logic [TW-1:0] t_prev_q;
    logic [1:0]    octmr_q;
    logic          oc_q, oc_d;
    logic          ocmf_q;
    logic          pulse_q;
    logic          ov_q, ov_d;

    logic [TW-1:0] head;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty;
    logic          match, recirc, wr_ok;
    logic          push0, push1;
    logic [TW-1:0] push0_data;

    assign mode = oc_mode_e'(OCM);

    always_comb begin
        case (OCTMR)
            OC_TMR0: t_cur = t_val_bi_0;
            OC_TMR1: t_cur = t_val_bi_1;
            default: t_cur = '0;
        endcase
    end

    // Fire only on the clock the timer steps onto the head value, never on a held value
    always_comb begin
        match = (mode != OC_OFF) && !OCTMR[1] && (count != '0) &&
                (t_cur == head) && (t_cur != t_prev_q) && (OCTMR == octmr_q);
        recirc = match && (mode == OC_CYCLIC);
        wr_ok  = wr_i && ((count != CW'(FIFO_DEPTH)) || (match && !recirc));
        push0      = recirc || wr_ok;
        push0_data = recirc ? head : OCBUF_i;
        push1      = recirc && wr_ok;
        ov_d   = (wr_i && !wr_ok) ? 1'b1 : (clr_i ? 1'b0 : ov_q);
    end

    always_comb begin
        oc_d = oc_q;
        if (mode == OC_OFF) begin
            oc_d = 1'b0;
        end else if (match) begin
            oc_d = (mode == OC_PULSE) ? 1'b1 : ~oc_q;
        end else if (pulse_q) begin
            oc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_prev_q <= '0;
            octmr_q  <= 2'b00;
            oc_q     <= 1'b0;
            ocmf_q   <= 1'b0;
            pulse_q  <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            t_prev_q <= t_cur;
            octmr_q  <= OCTMR;
            oc_q     <= oc_d;
            ocmf_q   <= match;
            pulse_q  <= match && (mode == OC_PULSE);
            ov_q     <= ov_d;
        end
    end

    output_compare_gen_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (push0),
        .push0_data_i (push0_data),
        .push1_i      (push1),
        .push1_data_i (OCBUF_i),
        .pop_i        (match),
        .head_o       (head),
        .count_o      (count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign oc_out = oc_q;
    assign OCMF   = ocmf_q;
    assign OCBNF  = ~fifo_full;
    assign OCBE   = fifo_empty;
    assign OCOV   = ov_q;

endmodule

// File: tb/tb_output_compare_gen.sv
// tb/tb_output_compare_gen.sv - directed self-checking bench for output_compare_gen
module tb_output_compare_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  OCTMR;
    logic [1:0]  OCM;
    logic [15:0] t_val_bi_0;
    logic [15:0] t_val_bi_1;
    logic        wr_i;
    logic [15:0] OCBUF_i;
    logic        clr_i;
    logic        oc_out, OCMF, OCBNF, OCBE, OCOV;

    int checks   = 0;
    int failures = 0;

    output_compare_gen #(.FIFO_DEPTH(4), .TW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .OCTMR      (OCTMR),
        .OCM        (OCM),
        .t_val_bi_0 (t_val_bi_0),
        .t_val_bi_1 (t_val_bi_1),
        .wr_i       (wr_i),
        .OCBUF_i    (OCBUF_i),
        .clr_i      (clr_i),
        .oc_out     (oc_out),
        .OCMF       (OCMF),
        .OCBNF      (OCBNF),
        .OCBE       (OCBE),
        .OCOV       (OCOV)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_i = 1'b0; clr_i = 1'b0;
        t_val_bi_0 = '0; t_val_bi_1 = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        wr_i = 1'b1; OCBUF_i = v;
        tick();
        wr_i = 1'b0;
    endtask

    task automatic test_reset();
        OCTMR = 2'b00; OCM = 2'b00; OCBUF_i = '0;
        do_reset();
        checks++;
        if ({oc_out, OCMF, OCBNF, OCBE, OCOV} !== 5'b00110) begin
            failures++;
            $display("FAIL reset_state got=%b want=00110", {oc_out, OCMF, OCBNF, OCBE, OCOV});
        end
    endtask

    task automatic test_toggle();
        int n_mf = 0;
        logic exp_oc;
        do_reset();
        OCTMR = 2'b00; OCM = 2'b01;
        push(16'd10); push(16'd20); push(16'd30);
        checks++;
        if (OCBE !== 1'b0) begin failures++; $display("FAIL toggle_not_empty got=%b want=0", OCBE); end
        for (int t = 0; t <= 40; t++) begin
            t_val_bi_0 = 16'(t);
            tick();
            exp_oc = (t >= 10 && t < 20) || (t >= 30);
            checks++;
            if (oc_out !== exp_oc || OCMF !== (t == 10 || t == 20 || t == 30)) begin
                failures++;
                $display("FAIL toggle_wave t=%0d got oc=%b mf=%b want oc=%b", t, oc_out, OCMF, exp_oc);
            end
            if (OCMF === 1'b1) n_mf++;
        end
        checks++;
        if (n_mf != 3 || OCBE !== 1'b1) begin
            failures++;
            $display("FAIL toggle_summary got mf=%0d be=%b want mf=3 be=1", n_mf, OCBE);
        end
    endtask

    task automatic test_prescaled();
        int n_mf = 0;
        do_reset();
        OCTMR = 2'b01; OCM = 2'b01;
        push(16'd5);
        for (int v = 0; v <= 8; v++) begin
            t_val_bi_1 = 16'(v);
            for (int k = 0; k < 4; k++) begin
                tick();
                if (OCMF === 1'b1) n_mf++;
            end
        end
        checks++;
        if (n_mf != 1 || oc_out !== 1'b1) begin
            failures++;
            $display("FAIL prescaled got mf=%0d oc=%b want mf=1 oc=1", n_mf, oc_out);
        end
    endtask

    task automatic test_pulse();
        do_reset();
        OCTMR = 2'b00; OCM = 2'b10;
        push(16'd100);
        for (int pass = 0; pass < 2; pass++) begin
            for (int t = 95; t <= 105; t++) begin
                t_val_bi_0 = 16'(t);
                tick();
                checks++;
                if (oc_out !== (pass == 0 && t == 100) || OCMF !== (pass == 0 && t == 100)) begin
                    failures++;
                    $display("FAIL pulse pass=%0d t=%0d got oc=%b mf=%b", pass, t, oc_out, OCMF);
                end
            end
        end
    endtask

    task automatic test_cyclic();
        int n_mf = 0;
        logic exp_oc = 1'b0;
        logic be_seen = 1'b0;
        logic wave_bad = 1'b0;
        do_reset();
        OCTMR = 2'b00; OCM = 2'b11;
        push(16'h0010); push(16'h0020);
        for (int rep = 0; rep < 3; rep++) begin
            for (int t = 0; t < 256; t++) begin
                t_val_bi_0 = 16'(t);
                tick();
                if (t == 16 || t == 32) exp_oc = ~exp_oc;
                if (oc_out !== exp_oc) wave_bad = 1'b1;
                if (OCBE !== 1'b0) be_seen = 1'b1;
                if (OCMF === 1'b1) n_mf++;
            end
        end
        checks++;
        if (n_mf != 6 || wave_bad || be_seen || oc_out !== 1'b0) begin
            failures++;
            $display("FAIL cyclic got mf=%0d wave_bad=%b be_seen=%b oc=%b want 6 0 0 0", n_mf, wave_bad, be_seen, oc_out);
        end
        OCM = 2'b00;
        push(16'h0100); push(16'h0200);
        checks++;
        if (OCBNF !== 1'b0 || OCOV !== 1'b0) begin
            failures++;
            $display("FAIL cyclic_count got bnf=%b ov=%b want 0 0", OCBNF, OCOV);
        end
        push(16'h0300);
        checks++;
        if (OCOV !== 1'b1) begin failures++; $display("FAIL cyclic_count_ov got=%b want=1", OCOV); end
    endtask

    task automatic test_overflow();
        do_reset();
        OCTMR = 2'b00; OCM = 2'b00;
        for (int i = 1; i <= 4; i++) push(16'(i * 7));
        checks++;
        if (OCBNF !== 1'b0 || OCOV !== 1'b0 || OCBE !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full got bnf=%b ov=%b be=%b want 0 0 0", OCBNF, OCOV, OCBE);
        end
        push(16'd99);
        checks++;
        if (OCOV !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", OCOV); end
        clr_i = 1'b1;
        push(16'd98);
        checks++;
        if (OCOV !== 1'b1) begin failures++; $display("FAIL ovf_set_beats_clr got=%b want=1", OCOV); end
        tick();
        clr_i = 1'b0;
        checks++;
        if (OCOV !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b want=0", OCOV); end
    endtask

    task automatic test_back_to_back();
        int n_mf = 0;
        do_reset();
        OCTMR = 2'b00; OCM = 2'b00;
        push(16'd50); push(16'd60); push(16'd70); push(16'd80);
        OCM = 2'b01;
        t_val_bi_0 = 16'd49;
        tick();
        t_val_bi_0 = 16'd50;
        wr_i = 1'b1; OCBUF_i = 16'd90;
        tick();
        wr_i = 1'b0;
        checks++;
        if (OCMF !== 1'b1 || OCOV !== 1'b0 || OCBNF !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_write got mf=%b ov=%b bnf=%b want 1 0 0", OCMF, OCOV, OCBNF);
        end
        for (int t = 51; t <= 95; t++) begin
            t_val_bi_0 = 16'(t);
            tick();
            if (OCMF === 1'b1) n_mf++;
        end
        checks++;
        if (n_mf != 4 || oc_out !== 1'b1 || OCBE !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_drain got mf=%0d oc=%b be=%b want 4 1 1", n_mf, oc_out, OCBE);
        end
    endtask

    task automatic test_held_value();
        int n_mf = 0;
        do_reset();
        OCTMR = 2'b00; OCM = 2'b01;
        t_val_bi_0 = 16'd200;
        tick(); tick();
        push(16'd200);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (OCMF === 1'b1) n_mf++;
        end
        checks++;
        if (n_mf != 0 || oc_out !== 1'b0 || OCBE !== 1'b0) begin
            failures++;
            $display("FAIL held_value got mf=%0d oc=%b be=%b want 0 0 0", n_mf, oc_out, OCBE);
        end
    endtask

    task automatic test_reset_midrun();
        int n_mf = 0;
        do_reset();
        OCTMR = 2'b00; OCM = 2'b01;
        push(16'd5); push(16'd10); push(16'd20); push(16'd30); push(16'd40);
        for (int t = 1; t <= 5; t++) begin
            t_val_bi_0 = 16'(t);
            tick();
        end
        checks++;
        if (oc_out !== 1'b1 || OCOV !== 1'b1) begin
            failures++;
            $display("FAIL midrun_setup got oc=%b ov=%b want 1 1", oc_out, OCOV);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({oc_out, OCBE, OCBNF, OCOV} !== 4'b0110) begin
            failures++;
            $display("FAIL midrun_reset got=%b want=0110", {oc_out, OCBE, OCBNF, OCOV});
        end
        for (int t = 0; t <= 40; t++) begin
            t_val_bi_0 = 16'(t);
            tick();
            if (OCMF === 1'b1 || oc_out !== 1'b0) n_mf++;
        end
        checks++;
        if (n_mf != 0) begin failures++; $display("FAIL midrun_no_match got events=%0d want=0", n_mf); end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_prescaled();
        test_pulse();
        test_cyclic();
        test_overflow();
        test_back_to_back();
        test_held_value();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
